// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: FSM states,
// common keyboard command bytes and the frame parity helper.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE
    } txState_t;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic oddParity(input logic [7:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one raw PS/2 pad input: 2-flop synchronizer followed by a
// FILTER_LEN-sample agreement filter that only changes on a unanimous window.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic Clock,
    input  logic Reset,
    input  logic iLine,
    output logic oLine
);

    logic [1:0]            sync;
    logic [FILTER_LEN-1:0] samples;

    // The bus idles high, so every stage resets to 1 to avoid a false edge
    // as soon as reset is released.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync    <= 2'b11;
            samples <= '1;
            oLine   <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the old
            // value of the previous one, which is what turns this into a shift chain.
            sync    <= {sync[0], iLine};
            samples <= {samples[FILTER_LEN-2:0], sync[1]};
            if (&samples)
                oLine <= 1'b1;
            else if (~|samples)
                oLine <= 1'b0;
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame clocked by
// the device, ACK capture and inter-edge timeout.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iStart,
    input  logic [7:0] iData,
    input  logic       iPS2Clk,
    input  logic       iPS2Data,
    output logic       oPS2ClkDriveLow,
    output logic       oPS2DataDriveLow,
    output logic       oBusy,
    output logic       oRxInhibit,
    output logic       oDone,
    output logic       oAck,
    output logic       oError
);

    // One counter serves both the inhibit interval and the edge timeout.
    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INHIBIT_PRE  = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    txState_t         state;
    logic [8:0]       shReg;
    logic [3:0]       bitCnt;
    logic [CNT_W-1:0] cnt;
    logic             ackReg;
    logic             clkFilt;
    logic             dataFilt;
    logic             clkFiltQ;
    logic             fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) uClkFilter (
        .Clock (Clock),
        .Reset (Reset),
        .iLine (iPS2Clk),
        .oLine (clkFilt)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) uDataFilter (
        .Clock (Clock),
        .Reset (Reset),
        .iLine (iPS2Data),
        .oLine (dataFilt)
    );

    assign fall       = clkFiltQ & ~clkFilt;
    assign oRxInhibit = oBusy;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            // NOTE: the drive enables sit on the async reset, so a mid-frame
            // reset releases both pads immediately without waiting for a clock.
            state            <= IDLE;
            shReg            <= '0;
            bitCnt           <= '0;
            cnt              <= '0;
            ackReg           <= 1'b0;
            clkFiltQ         <= 1'b1;
            oPS2ClkDriveLow  <= 1'b0;
            oPS2DataDriveLow <= 1'b0;
            oBusy            <= 1'b0;
            oDone            <= 1'b0;
            oAck             <= 1'b0;
            oError           <= 1'b0;
        end else begin
            clkFiltQ <= clkFilt;
            oDone    <= 1'b0;
            oAck     <= 1'b0;
            oError   <= 1'b0;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        shReg           <= {oddParity(iData), iData};
                        oBusy           <= 1'b1;
                        oPS2ClkDriveLow <= 1'b1;
                        cnt             <= '0;
                        state           <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == INHIBIT_PRE)
                        oPS2DataDriveLow <= 1'b1;
                    if (cnt == INHIBIT_LAST) begin
                        oPS2ClkDriveLow <= 1'b0;
                        cnt             <= '0;
                        state           <= RTS;
                    end
                end
                default: begin
                    if (state == WAIT_IDLE && clkFilt && dataFilt) begin
                        oDone <= 1'b1;
                        oAck  <= ackReg;
                        oBusy <= 1'b0;
                        state <= IDLE;
                    end else if (fall) begin
                        // Bits only change while the device holds clock low.
                        cnt <= '0;
                        case (state)
                            RTS: begin
                                oPS2DataDriveLow <= ~shReg[0];
                                shReg            <= {1'b0, shReg[8:1]};
                                bitCnt           <= 4'd1;
                                state            <= SEND;
                            end
                            SEND: begin
                                if (bitCnt == 4'd9) begin
                                    oPS2DataDriveLow <= 1'b0;
                                    state            <= ACK;
                                end else begin
                                    oPS2DataDriveLow <= ~shReg[0];
                                    shReg            <= {1'b0, shReg[8:1]};
                                    bitCnt           <= bitCnt + 1'b1;
                                end
                            end
                            ACK: begin
                                ackReg <= ~dataFilt;
                                state  <= WAIT_IDLE;
                            end
                            default: ;
                        endcase
                    end else if (cnt == TIMEOUT_LAST) begin
                        oPS2ClkDriveLow  <= 1'b0;
                        oPS2DataDriveLow <= 1'b0;
                        oError           <= 1'b1;
                        oBusy            <= 1'b0;
                        bitCnt           <= '0;
                        cnt              <= '0;
                        state            <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter, the send side of the keyboard link whose receive side already feeds TEC. It sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard using the PS/2 request-to-send sequence. It drives both open-drain PS/2 lines through active-low drive enables and returns done, ack and error status to the MiniAlu datapath. While it owns the bus, it tells the receive path to ignore the lines.

Parameters:
INHIBIT_CYCLES, 5000, Clock cycles the PS/2 clock line is held low before request-to-send (100 us at 50 MHz).
TIMEOUT_CYCLES, 750000, maximum Clock cycles between consecutive filtered device falling edges (15 ms at 50 MHz).
FILTER_LEN, 8, depth of the glitch filter on each PS/2 input line.

Ports:
Clock  in  1  system clock, 50 MHz
Reset  in  1  asynchronous, active-high reset
iStart  in  1  single-cycle request to send iData; accepted only when oBusy=0
iData  in  8  command byte; latched on acceptance
iPS2Clk  in  1  raw PS/2 clock line (pad input)
iPS2Data  in  1  raw PS/2 data line (pad input)
oPS2ClkDriveLow  out  1  1 = pull PS/2 clock low; 0 = release (pad tri-state)
oPS2DataDriveLow  out  1  1 = pull PS/2 data low; 0 = release
oBusy  out  1  high from acceptance until return to IDLE
oRxInhibit  out  1  equals oBusy; receive path discards bits while high
oDone  out  1  one-cycle pulse at the end of a successful or NACKed frame
oAck  out  1  valid with oDone: 1 = device acknowledged (data low at 11th edge)
oError  out  1  one-cycle pulse on timeout; oDone is not pulsed in that case

Behaviour:
- Reset (async) forces:
  - state IDLE; all outputs 0 (both lines released);
  - shift register and counters 0; filter outputs 1.
- Input conditioning: each raw line passes a 2-flop synchronizer, then the FILTER_LEN filter.
  - Filtered value goes to 1 when all FILTER_LEN samples are 1, and to 0 when all are 0; otherwise it holds.
  - A falling edge (fall) is a filtered clock transition 1 to 0, detected as a one-cycle strobe.
- Parity: odd, computed as the inverse of the XOR of the 8 data bits; latched with the data at acceptance.
- FSM:
  - IDLE: on iStart, latch {parity, iData}, set oBusy and go to INHIBIT. iStart while busy is ignored.
  - INHIBIT: ClkDriveLow=1 for INHIBIT_CYCLES cycles.
    - At cycle INHIBIT_CYCLES-1, set DataDriveLow=1 (start bit).
    - Next cycle: ClkDriveLow=0, go to RTS.
  - RTS: hold data low and wait for fall.
    - On fall: drive bit0 (DataDriveLow = ~bit), bitcnt=1, go to SEND.
  - SEND: on each fall, drive the next bit, LSB first; bit 8 is parity.
    - After parity has been driven, the next fall releases data (stop=1) and goes to ACK.
  - ACK: on fall, sample filtered data; oAck_reg = ~data. Go to WAIT_IDLE.
  - WAIT_IDLE: when filtered clock=1 and filtered data=1, pulse oDone with oAck, go to IDLE.
- Data changes only on the fall strobe, i.e. while the device holds clock low, so bits are stable for the device's rising-edge sample.
- Timeout counter:
  - cleared on every fall and on entry to RTS;
  - counts in RTS, SEND, ACK and WAIT_IDLE;
  - on reaching TIMEOUT_CYCLES: release both lines, pulse oError, go to IDLE.
- Reset mid-frame: lines are released immediately and asynchronously; no oDone or oError pulse.
- NACK (data high at the ACK edge) is not an error: oDone=1, oAck=0. Retry is software's responsibility.
- The FSM never drives a line high; release is the only way a line goes high.
- Output latency: oDone is asserted in the cycle after the IDLE condition is seen in WAIT_IDLE.

Decomposition:
- Shared package/definitions file:
  - FSM state encodings (IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE);
  - PS/2 command constants: PS2_CMD_SET_LEDS=8'hED, PS2_CMD_ECHO=8'hEE, PS2_CMD_RESET=8'hFF, PS2_RSP_ACK=8'hFA.
- Sub-module ps2_line_filter (synchronizer plus FILTER_LEN filter), instantiated twice. The receive path should reuse it in place of its inline filters.

Test Plan:
- Send 0xED with a device model that clocks at 12.5 kHz and ACKs. Required: clock held low for 5000 cycles; data low before clock release; bits on data in order 1,0,1,1,0,1,1,1, then parity 1, then stop released; oDone=1 and oAck=1 in one pulse; oBusy falls the same cycle.
- Send 0x00 with a NACKing device. Required: parity bit 1; oDone=1, oAck=0; no oError.
- Device never clocks after release. Required: oError pulses exactly TIMEOUT_CYCLES cycles after entry to RTS; both drive outputs 0; oBusy=0.
- Assert Reset during SEND, after bit 4. Required: drive outputs go to 0 in the same cycle without a clock edge; next iStart of 0xFF completes normally with oAck=1.
- Inject 3-cycle low glitches on iPS2Clk during SEND. Required: no bit advance; the transmitted byte is unchanged.
- iStart pulsed again while busy, with 0x55. Required: ignored; only the first byte appears on the line; a single oDone.
